// File: rtl/sig_monitor.sv
// sig_monitor: safety monitor and lamp driver between the signal controller
// and the signal heads. Decodes 2-bit head codes to one-hot {R,Y,G} lamps,
// checks every sample against the signalling rules and latches a fault that
// flashes both heads red until cleared.
// Optional minimum yellow / all-red dwell checking: define SIGMON_DWELL_EN.
`timescale 1ns/1ps

module sig_monitor #(
    parameter int unsigned MIN_YELLOW = 1,
    parameter int unsigned MIN_ALLRED = 1,
    parameter int unsigned FLASH_HALF = 4
) (
    input  logic       clock,
    input  logic       clear_n,
    input  logic [1:0] hwy,
    input  logic [1:0] cntry,
    input  logic       clr_fault,
    output logic [2:0] hwy_lamp,
    output logic [2:0] cntry_lamp,
    output logic       fault,
    output logic [2:0] fault_code
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    localparam logic [1:0] SIG_INV = 2'b00;
    localparam logic [1:0] SIG_RED = 2'b01;
    localparam logic [1:0] SIG_YEL = 2'b10;
    localparam logic [1:0] SIG_GRN = 2'b11;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    localparam logic [15:0] FLASH_LAST = 16'(FLASH_HALF - 1);

    state_t     r_state,       w_state_nxt;
    logic [2:0] r_hwy_lamp,    w_hwy_lamp_nxt;
    logic [2:0] r_cntry_lamp,  w_cntry_lamp_nxt;
    logic [2:0] r_code,        w_code_nxt;
    logic [1:0] r_prev_hwy,    w_prev_hwy_nxt;
    logic [1:0] r_prev_cntry,  w_prev_cntry_nxt;
    logic       r_flash_on,    w_flash_on_nxt;
    logic [15:0] r_flash_cnt,  w_flash_cnt_nxt;

    logic [2:0] w_viol;
    logic       w_legal_hwy;
    logic       w_legal_cntry;
    logic       w_exit;

`ifdef SIGMON_DWELL_EN
    logic [7:0] r_ycnt_hwy,    w_ycnt_hwy_nxt;
    logic [7:0] r_ycnt_cntry,  w_ycnt_cntry_nxt;
    logic [7:0] r_allred,      w_allred_nxt;
    logic       w_short_yel;
    logic       w_short_allred;
`else
    logic       w_unused_cfg;
    assign w_unused_cfg = ^{MIN_YELLOW, MIN_ALLRED};
`endif

    function automatic logic f_legal(input logic [1:0] p, input logic [1:0] n);
        return (p == n) ||
               (p == SIG_GRN && n == SIG_YEL) ||
               (p == SIG_YEL && n == SIG_RED) ||
               (p == SIG_RED && n == SIG_GRN);
    endfunction

    function automatic logic [2:0] f_lamp(input logic [1:0] s);
        case (s)
            SIG_YEL: return LAMP_YEL;
            SIG_GRN: return LAMP_GRN;
            default: return LAMP_RED;
        endcase
    endfunction

    function automatic logic [7:0] f_sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign w_legal_hwy   = f_legal(r_prev_hwy, hwy);
    assign w_legal_cntry = f_legal(r_prev_cntry, cntry);
    assign w_exit        = clr_fault && (hwy == SIG_RED) && (cntry == SIG_RED);

`ifdef SIGMON_DWELL_EN
    assign w_short_yel =
        (r_prev_hwy   == SIG_YEL && hwy   == SIG_RED && {24'd0, r_ycnt_hwy}   < MIN_YELLOW) ||
        (r_prev_cntry == SIG_YEL && cntry == SIG_RED && {24'd0, r_ycnt_cntry} < MIN_YELLOW);
    assign w_short_allred =
        ((r_prev_hwy == SIG_RED && hwy == SIG_GRN) || (r_prev_cntry == SIG_RED && cntry == SIG_GRN)) &&
        ({24'd0, r_allred} < MIN_ALLRED);
`endif

    // Rule check on the current sample; lowest violation code wins.
    always_comb begin
        w_viol = 3'd0;
        if (hwy != SIG_RED && cntry != SIG_RED)      w_viol = 3'd1;
        else if (hwy == SIG_INV || cntry == SIG_INV) w_viol = 3'd2;
        else if (!w_legal_hwy || !w_legal_cntry)     w_viol = 3'd3;
`ifdef SIGMON_DWELL_EN
        else if (w_short_yel)                        w_viol = 3'd4;
        else if (w_short_allred)                     w_viol = 3'd5;
`endif
    end

    // Next-state, lamp, history and flash computation for RUN / FAULT.
    always_comb begin
        w_state_nxt      = r_state;
        w_code_nxt       = r_code;
        w_hwy_lamp_nxt   = r_hwy_lamp;
        w_cntry_lamp_nxt = r_cntry_lamp;
        w_prev_hwy_nxt   = r_prev_hwy;
        w_prev_cntry_nxt = r_prev_cntry;
        w_flash_on_nxt   = r_flash_on;
        w_flash_cnt_nxt  = r_flash_cnt;
`ifdef SIGMON_DWELL_EN
        w_ycnt_hwy_nxt   = r_ycnt_hwy;
        w_ycnt_cntry_nxt = r_ycnt_cntry;
        w_allred_nxt     = r_allred;
`endif
        case (r_state)
            ST_RUN: begin
                if (w_viol != 3'd0) begin
                    w_state_nxt      = ST_FAULT;
                    w_code_nxt       = w_viol;
                    w_hwy_lamp_nxt   = LAMP_RED;
                    w_cntry_lamp_nxt = LAMP_RED;
                    w_flash_on_nxt   = 1'b1;
                    w_flash_cnt_nxt  = '0;
                end else begin
                    w_hwy_lamp_nxt   = f_lamp(hwy);
                    w_cntry_lamp_nxt = f_lamp(cntry);
                    w_prev_hwy_nxt   = hwy;
                    w_prev_cntry_nxt = cntry;
`ifdef SIGMON_DWELL_EN
                    w_ycnt_hwy_nxt   = (hwy == SIG_YEL) ? f_sat_inc(r_ycnt_hwy) : '0;
                    w_ycnt_cntry_nxt = (cntry == SIG_YEL) ? f_sat_inc(r_ycnt_cntry) : '0;
                    w_allred_nxt     = (hwy == SIG_RED && cntry == SIG_RED) ? f_sat_inc(r_allred) : '0;
`endif
                end
            end
            ST_FAULT: begin
                if (w_exit) begin
                    w_state_nxt      = ST_RUN;
                    w_code_nxt       = '0;
                    w_hwy_lamp_nxt   = LAMP_RED;
                    w_cntry_lamp_nxt = LAMP_RED;
                    w_prev_hwy_nxt   = SIG_RED;
                    w_prev_cntry_nxt = SIG_RED;
                    w_flash_on_nxt   = 1'b1;
                    w_flash_cnt_nxt  = '0;
`ifdef SIGMON_DWELL_EN
                    w_ycnt_hwy_nxt   = '0;
                    w_ycnt_cntry_nxt = '0;
                    w_allred_nxt     = 8'd1;
`endif
                end else begin
                    if (r_flash_cnt == FLASH_LAST) begin
                        w_flash_cnt_nxt = '0;
                        w_flash_on_nxt  = ~r_flash_on;
                    end else begin
                        w_flash_cnt_nxt = r_flash_cnt + 16'd1;
                    end
                    w_hwy_lamp_nxt   = w_flash_on_nxt ? LAMP_RED : LAMP_OFF;
                    w_cntry_lamp_nxt = w_flash_on_nxt ? LAMP_RED : LAMP_OFF;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // State and output registers; asynchronous reset to RUN with red lamps.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_state      <= ST_RUN;
            r_code       <= '0;
            r_hwy_lamp   <= LAMP_RED;
            r_cntry_lamp <= LAMP_RED;
            r_prev_hwy   <= SIG_RED;
            r_prev_cntry <= SIG_RED;
            r_flash_on   <= 1'b1;
            r_flash_cnt  <= '0;
`ifdef SIGMON_DWELL_EN
            r_ycnt_hwy   <= '0;
            r_ycnt_cntry <= '0;
            r_allred     <= '1;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_code       <= w_code_nxt;
            r_hwy_lamp   <= w_hwy_lamp_nxt;
            r_cntry_lamp <= w_cntry_lamp_nxt;
            r_prev_hwy   <= w_prev_hwy_nxt;
            r_prev_cntry <= w_prev_cntry_nxt;
            r_flash_on   <= w_flash_on_nxt;
            r_flash_cnt  <= w_flash_cnt_nxt;
`ifdef SIGMON_DWELL_EN
            r_ycnt_hwy   <= w_ycnt_hwy_nxt;
            r_ycnt_cntry <= w_ycnt_cntry_nxt;
            r_allred     <= w_allred_nxt;
`endif
        end
    end

    assign hwy_lamp   = r_hwy_lamp;
    assign cntry_lamp = r_cntry_lamp;
    assign fault      = (r_state == ST_FAULT);
    assign fault_code = r_code;

endmodule
